ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Execute/memory pipeline boundary. It sits directly downstream of the ALU and captures alu out/zero/overflow together with the instruction's control bits.
- It presents registered values to the memory stage, resolves conditional branches from the ALU zero flag, and converts signed-arithmetic overflow into a precise trap.
- A two-state trap FSM and a valid/stall/flush handshake give the block its sequential behaviour.

Parameters:
- N, 32, datapath width.
- CNT_W, 8, width of the saturating overflow-event counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX stage holds a valid instruction
- in_ready  out  1  block can accept this cycle; combinational, equals !mem_stall
- ex_pc  in  N  PC of the EX instruction
- alu_out  in  N  ALU result
- alu_zero  in  1  ALU zero flag; for BEQ/BNE aluops, 1 means branch condition true
- alu_overflow  in  1  ALU overflow flag
- ex_trap_ov  in  1  instruction traps on overflow (add/sub/addi; not the unsigned forms)
- ex_rt_data  in  N  store data
- ex_rd  in  5  destination register
- ex_regwrite  in  1  control bit
- ex_memread  in  1  control bit
- ex_memwrite  in  1  control bit
- ex_branch  in  1  conditional branch
- ex_branch_target  in  N  branch target
- mem_stall  in  1  memory stage cannot advance
- flush  in  1  kill the instruction being captured
- exc_ack  in  1  exception handler has taken the trap
- mem_valid  out  1  memory-stage instruction valid
- mem_pc  out  N
- mem_alu_out  out  N
- mem_wdata  out  N
- mem_rd  out  5
- mem_regwrite  out  1
- mem_memread  out  1
- mem_memwrite  out  1
- branch_taken  out  1  one-cycle redirect pulse
- branch_pc  out  N  redirect target
- exc_valid  out  1  trap pending
- exc_cause  out  5  trap cause code
- epc  out  N  PC of the trapping instruction
- ov_count  out  CNT_W  saturating count of overflow traps

Behaviour:
- Reset (async, active-high): all outputs 0, state = RUN.
- Latency: 1 cycle, all outputs registered. Per-edge priority: flush > mem_stall > load.
- accept = in_valid & !mem_stall & !flush & state==RUN.
- trap = accept & alu_overflow & ex_trap_ov.
- Normal load (accept & !trap): mem_* take the ex_* and alu_out values; mem_valid = 1; branch_taken = ex_branch & alu_zero; branch_pc = ex_branch_target.
- Trap load:
  - mem_valid = 0 and all mem control bits = 0, so the instruction is suppressed.
  - epc = ex_pc; exc_cause = EXC_OV (12); exc_valid = 1; state -> TRAP.
  - ov_count increments, saturating at all-ones.
  - branch_taken = 0.
- Bubble (!in_valid & !mem_stall & !flush): mem_valid = 0, controls 0, data fields hold.
- Stall (mem_stall & !flush): all mem_* hold; branch_taken = 0. The pulse never repeats, even if the stall starts on the pulse cycle.
- Flush: next cycle mem_valid = 0, controls 0, branch_taken = 0.
  - A same-cycle in_valid instruction is dropped and cannot trap.
  - Flush does not change the FSM state, epc, exc_cause or ov_count.
- Control bits are never 1 while mem_valid = 0.
- FSM, RUN: as above. exc_ack is ignored.
- FSM, TRAP:
  - exc_valid held at 1.
  - Incoming instructions are consumed (in_ready still !mem_stall) but become bubbles. No new trap is raised and ov_count does not change.
  - exc_ack = 1 -> RUN on the next edge with exc_valid = 0. The same-cycle instruction is still discarded.
  - epc/exc_cause hold until the next trap.
- Reset mid-TRAP: immediate return to RUN, all outputs 0.
- Arithmetic: only the ov_count increment; no wrap.

Decomposition:
- Shared defines file (existing, alongside the ALUOP codes): EXC_OV = 5'd12, and the state encodings ST_RUN = 1'b0, ST_TRAP = 1'b1.
- No sub-module. The FSM and register bank are a single flat module.

Test Plan:
- Normal ALU op: in_valid=1, alu_out=0x0000_0007, ex_rd=5, ex_regwrite=1 -> next cycle mem_valid=1, mem_alu_out=7, mem_rd=5, mem_regwrite=1, exc_valid=0.
- Branch taken under stall:
  - Stimulus: ex_branch=1, alu_zero=1, target 0x0040_0020; then mem_stall=1 for 3 cycles.
  - Response: branch_taken=1 for exactly one cycle, branch_pc=0x0040_0020; mem_* held during the stall.
- Overflow trap:
  - Stimulus: ex_pc=0x0040_0010, alu_overflow=1, ex_trap_ov=1, ex_regwrite=1.
  - Response: mem_valid=0, mem_regwrite=0, exc_valid=1, epc=0x0040_0010, exc_cause=12, ov_count=1.
  - Next 2 instructions are bubbles; exc_ack -> exc_valid=0 one cycle later, and the following instruction loads normally.
- Unsigned overflow: alu_overflow=1, ex_trap_ov=0 -> normal load, no trap, ov_count unchanged.
- Flush and stall contention: flush=1 with mem_stall=1 and in_valid=1 with overflow -> mem_valid=0, no trap, state stays RUN.
- Counter and reset: 256 traps (each acked) -> ov_count saturates at 0xFF; assert reset while in TRAP -> every output 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared pipeline defines (ALU op codes, trap causes, EX/MEM FSM states).
// Revision: 1.0
`default_nettype none

package ex_mem_reg_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_ADDU = 4'd2;
  localparam logic [3:0] ALUOP_SUBU = 4'd3;
  localparam logic [3:0] ALUOP_BEQ  = 4'd4;
  localparam logic [3:0] ALUOP_BNE  = 4'd5;

  localparam logic [4:0] EXC_OV = 5'd12;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution and precise overflow trap.
// Revision: 1.0
`default_nettype none

module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     ex_pc,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             ex_trap_ov,
  input  logic [N-1:0]     ex_rt_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             ex_branch,
  input  logic [N-1:0]     ex_branch_target,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic             exc_ack,
  output logic             mem_valid,
  output logic [N-1:0]     mem_pc,
  output logic [N-1:0]     mem_alu_out,
  output logic [N-1:0]     mem_wdata,
  output logic [4:0]       mem_rd,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             branch_taken,
  output logic [N-1:0]     branch_pc,
  output logic             exc_valid,
  output logic [4:0]       exc_cause,
  output logic [N-1:0]     epc,
  output logic [CNT_W-1:0] ov_count
);

  state_t state, state_nxt;
  logic   accept, trap, load;

  assign in_ready  = ~mem_stall;
  assign accept    = in_valid & ~mem_stall & ~flush & (state == ST_RUN);
  assign trap      = accept & alu_overflow & ex_trap_ov;
  assign load      = accept & ~trap;
  assign exc_valid = (state == ST_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // A flush leaves the FSM untouched, so an acknowledge arriving with it is not taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (trap) state_nxt = ST_TRAP;
      ST_TRAP: if (exc_ack && !flush) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid    <= 1'b0;
      mem_pc       <= '0;
      mem_alu_out  <= '0;
      mem_wdata    <= '0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      branch_taken <= 1'b0;
      branch_pc    <= '0;
      exc_cause    <= '0;
      epc          <= '0;
      ov_count     <= '0;
    end else begin
      branch_taken <= 1'b0;
      if (flush || (!mem_stall && !load)) begin
        mem_valid    <= 1'b0;
        mem_regwrite <= 1'b0;
        mem_memread  <= 1'b0;
        mem_memwrite <= 1'b0;
      end else if (load) begin
        mem_valid    <= 1'b1;
        mem_pc       <= ex_pc;
        mem_alu_out  <= alu_out;
        mem_wdata    <= ex_rt_data;
        mem_rd       <= ex_rd;
        mem_regwrite <= ex_regwrite;
        mem_memread  <= ex_memread;
        mem_memwrite <= ex_memwrite;
        branch_taken <= ex_branch & alu_zero;
        branch_pc    <= ex_branch_target;
      end
      if (trap) begin
        epc       <= ex_pc;
        exc_cause <= EXC_OV;
        if (ov_count != {CNT_W{1'b1}}) ov_count <= ov_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: vector table, corner sequences and randomized run against a reference model.
// Revision: 1.0
`default_nettype none

module tb_ex_mem_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, alu;
    logic        zero, ovf, tov;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        regw, memr, memw, br;
    logic [31:0] tgt;
    logic        stall, flush, ack;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, alu, wdata;
    logic [4:0]  rd;
    logic        regw, memr, memw, bt;
    logic [31:0] bpc;
    logic        excv;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [7:0]  cnt;
  } out_t;

  typedef struct {
    in_t         stim;
    logic        v;
    logic [31:0] pc, alu;
    logic [4:0]  rd;
    logic        regw, bt;
    logic [31:0] bpc;
    logic        excv;
    logic [31:0] epc;
    logic [7:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, alu_zero, alu_overflow, ex_trap_ov;
  logic [31:0] ex_pc, alu_out, ex_rt_data, ex_branch_target;
  logic [4:0]  ex_rd, mem_rd, exc_cause;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic        mem_stall, flush, exc_ack;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, branch_taken, exc_valid;
  logic [31:0] mem_pc, mem_alu_out, mem_wdata, branch_pc, epc;
  logic [7:0]  ov_count;

  ex_mem_reg #(.N(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ex_pc(ex_pc), .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .ex_trap_ov(ex_trap_ov), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
    .mem_stall(mem_stall), .flush(flush), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .epc(epc), .ov_count(ov_count)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t exp_o;
  in_t  cur;
  vec_t tbl[$];

  function automatic in_t vin(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                              input logic zero, input logic ovf, input logic tov,
                              input logic [4:0] rd, input logic regw, input logic br,
                              input logic [31:0] tgt, input logic stall, input logic fl,
                              input logic ack);
    in_t i;
    i       = '0;
    i.valid = v;   i.pc  = pc;  i.alu = alu; i.zero  = zero; i.ovf   = ovf;
    i.tov   = tov; i.rd  = rd;  i.regw = regw; i.br  = br;   i.tgt   = tgt;
    i.stall = stall; i.flush = fl; i.ack = ack;
    i.wdata = alu ^ 32'h0F0F_0F0F;
    return i;
  endfunction

  // What the memory stage should see after one edge, given the previous view and the EX inputs.
  function automatic out_t ref_next(input out_t e, input in_t i);
    out_t n;
    logic taking, ov_trap, moves;
    n       = e;
    n.bt    = 1'b0;
    moves   = !i.flush && !i.stall;
    taking  = moves && i.valid && !e.excv;
    ov_trap = taking && i.ovf && i.tov;
    if (taking && !ov_trap) begin
      n.valid = 1'b1;  n.pc = i.pc; n.alu = i.alu; n.wdata = i.wdata; n.rd = i.rd;
      n.regw = i.regw; n.memr = i.memr; n.memw = i.memw;
      n.bt = i.br && i.zero; n.bpc = i.tgt;
    end else if (i.flush || moves) begin
      n.valid = 1'b0; n.regw = 1'b0; n.memr = 1'b0; n.memw = 1'b0;
    end
    if (ov_trap) begin
      n.excv = 1'b1; n.epc = i.pc; n.cause = 5'd12;
      n.cnt = (e.cnt == 8'd255) ? 8'd255 : e.cnt + 8'd1;
    end else if (e.excv && i.ack && !i.flush) begin
      n.excv = 1'b0;
    end
    return n;
  endfunction

  function automatic out_t dut_out();
    out_t a;
    a.valid = mem_valid;    a.pc = mem_pc; a.alu = mem_alu_out; a.wdata = mem_wdata;
    a.rd = mem_rd;          a.regw = mem_regwrite; a.memr = mem_memread;
    a.memw = mem_memwrite;  a.bt = branch_taken; a.bpc = branch_pc; a.excv = exc_valid;
    a.cause = exc_cause;    a.epc = epc; a.cnt = ov_count;
    return a;
  endfunction

  task automatic check_out(input string name, input out_t e);
    out_t a;
    a = dut_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_row(input int k);
    logic [141:0] a, e;
    a = {mem_valid, mem_pc, mem_alu_out, mem_rd, mem_regwrite, branch_taken, branch_pc,
         exc_valid, epc, ov_count};
    e = {tbl[k].v, tbl[k].pc, tbl[k].alu, tbl[k].rd, tbl[k].regw, tbl[k].bt, tbl[k].bpc,
         tbl[k].excv, tbl[k].epc, tbl[k].cnt};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL tbl[%0d]: got %h expected %h", k, a, e);
    end
  endtask

  task automatic step(input in_t i);
    cur              = i;
    in_valid         = i.valid;  ex_pc      = i.pc;    alu_out     = i.alu;
    alu_zero         = i.zero;   alu_overflow = i.ovf; ex_trap_ov  = i.tov;
    ex_rt_data       = i.wdata;  ex_rd      = i.rd;    ex_regwrite = i.regw;
    ex_memread       = i.memr;   ex_memwrite = i.memw; ex_branch   = i.br;
    ex_branch_target = i.tgt;    mem_stall  = i.stall; flush       = i.flush;
    exc_ack          = i.ack;
    @(posedge clk);
    #1;
    exp_o = ref_next(exp_o, cur);
  endtask

  initial begin
    in_t  tv, av, r;
    out_t zero_o;
    zero_o = '0;
    exp_o  = '0;
    reset  = 1'b1;
    step(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_o  = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("reset_state", zero_o);

    //              v  pc            alu           z  o  t  rd     rw br tgt           st fl ak |  v  pc            alu           rd     rw bt bpc           ev epc           cnt
    tbl.push_back('{vin(1, 32'h0040_0000, 32'h0000_0007, 0, 0, 0, 5'd5,  1, 0, 32'h0,         0, 0, 0), 1, 32'h0040_0000, 32'h0000_0007, 5'd5,  1, 0, 32'h0,         0, 32'h0,         8'd0});
    tbl.push_back('{vin(1, 32'h0040_0004, 32'h0000_0000, 1, 0, 0, 5'd0,  0, 1, 32'h0040_0020, 0, 0, 0), 1, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 1, 32'h0040_0020, 0, 32'h0,         8'd0});
    for (int s = 0; s < 3; s++)
      tbl.push_back('{vin(1, 32'h0040_0008, 32'h0000_0055, 0, 1, 1, 5'd9,  1, 1, 32'h0,         1, 0, 0), 1, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 0, 32'h0040_0020, 0, 32'h0,         8'd0});
    tbl.push_back('{vin(1, 32'h0040_0010, 32'h8000_0000, 0, 1, 1, 5'd3,  1, 0, 32'h0,         0, 0, 0), 0, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 0, 32'h0040_0020, 1, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0014, 32'h0000_0011, 0, 0, 0, 5'd4,  1, 0, 32'h0,         0, 0, 0), 0, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 0, 32'h0040_0020, 1, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0018, 32'h0000_0022, 0, 1, 1, 5'd6,  1, 0, 32'h0,         0, 0, 0), 0, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 0, 32'h0040_0020, 1, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_001C, 32'h0000_0033, 0, 0, 0, 5'd7,  1, 0, 32'h0,         0, 0, 1), 0, 32'h0040_0004, 32'h0000_0000, 5'd0,  0, 0, 32'h0040_0020, 0, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0040, 32'h0000_0044, 0, 0, 0, 5'd8,  1, 0, 32'h0,         0, 0, 0), 1, 32'h0040_0040, 32'h0000_0044, 5'd8,  1, 0, 32'h0,         0, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0044, 32'h7FFF_0000, 0, 1, 0, 5'd10, 1, 0, 32'h0,         0, 0, 0), 1, 32'h0040_0044, 32'h7FFF_0000, 5'd10, 1, 0, 32'h0,         0, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0048, 32'h0000_0099, 0, 1, 1, 5'd11, 1, 0, 32'h0,         1, 1, 0), 0, 32'h0040_0044, 32'h7FFF_0000, 5'd10, 0, 0, 32'h0,         0, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(0, 32'h0040_004C, 32'h0000_00AA, 0, 0, 0, 5'd12, 1, 0, 32'h0,         0, 0, 0), 0, 32'h0040_0044, 32'h7FFF_0000, 5'd10, 0, 0, 32'h0,         0, 32'h0040_0010, 8'd1});
    tbl.push_back('{vin(1, 32'h0040_0030, 32'hDEAD_BEEF, 0, 0, 0, 5'd31, 1, 0, 32'h0,         0, 0, 0), 1, 32'h0040_0030, 32'hDEAD_BEEF, 5'd31, 1, 0, 32'h0,         0, 32'h0040_0010, 8'd1});

    foreach (tbl[k]) begin
      step(tbl[k].stim);
      check_row(k);
      check_out($sformatf("tbl_model[%0d]", k), exp_o);
    end

    // Each trap is acknowledged so the next one can be raised; the counter must stop at 0xFF.
    tv = vin(1, 32'h0040_0100, 32'h0000_0001, 0, 1, 1, 5'd2, 1, 0, 32'h0, 0, 0, 0);
    av = vin(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 0, 0, 32'h0, 0, 0, 1);
    for (int k = 0; k < 256; k++) begin
      step(tv);
      step(av);
      if (k == 199) begin
        n_cmp++;
        if (ov_count !== 8'd201) begin
          n_bad++;
          $display("FAIL ov_count_mid: got %0d expected 201", ov_count);
        end
      end
    end
    n_cmp++;
    if (ov_count !== 8'hFF) begin
      n_bad++;
      $display("FAIL ov_count_sat: got %h expected ff", ov_count);
    end
    check_out("after_saturation", exp_o);

    step(tv);
    check_out("trap_before_reset", exp_o);
    #2 reset = 1'b1;
    #1;
    check_out("async_reset_in_trap", zero_o);
    #1 reset = 1'b0;
    exp_o = '0;

    for (int c = 0; c < 1500; c++) begin
      r       = '0;
      r.valid = ($urandom_range(3) != 0);
      r.pc    = $urandom;
      r.alu   = $urandom;
      r.zero  = ($urandom_range(1) != 0);
      r.ovf   = ($urandom_range(2) == 0);
      r.tov   = ($urandom_range(1) != 0);
      r.wdata = $urandom;
      r.rd    = 5'($urandom);
      r.regw  = ($urandom_range(1) != 0);
      r.memr  = ($urandom_range(1) != 0);
      r.memw  = ($urandom_range(1) != 0);
      r.br    = ($urandom_range(1) != 0);
      r.tgt   = $urandom;
      r.stall = ($urandom_range(3) == 0);
      r.flush = ($urandom_range(9) == 0);
      r.ack   = ($urandom_range(2) == 0);
      step(r);
      check_out("rand", exp_o);
      n_cmp++;
      if (in_ready !== !cur.stall) begin
        n_bad++;
        $display("FAIL in_ready: got %b expected %b", in_ready, !cur.stall);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
